// File: rtl/timebase_ctrl_pkg.sv
// Shared definitions for the timebase front end: default divider and
// debounce lengths, plus the RUN/PAUSED state encoding.
package timebase_ctrl_pkg;

  // 1 Hz from the 50 MHz board clock, and 20 ms of debounce at 50 MHz.
  localparam int DIV_1HZ = 50_000_000;
  localparam int DB_20MS = 1_000_000;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } run_state_e;

endpackage

// File: rtl/timebase_ctrl_key_debounce.sv
// Synchronizer, debouncer and press-pulse generator for one active-low key.
// Ports: clk, rst (async, active-high), key_n (raw key), press (1-cycle).
module key_debounce
  import timebase_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_20MS,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // Accept the new level; a press is the accepted 1->0 change,
        // so press rises together with the low level.
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Timing front end: 1 Hz tick prescaler gated by a RUN/PAUSED FSM.
// Ports: CLK, RST (async, active-high), key_n[1:0] (raw, active-low:
// [0]=clear, [1]=run/pause), tick, clr_pulse, running, paused.
module timebase_ctrl
  import timebase_ctrl_pkg::*;
#(
  parameter int DIV       = DIV_1HZ,
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = DB_20MS,
  parameter int DB_W      = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] key_n,
  output logic       tick,
  output logic       clr_pulse,
  output logic       running,
  output logic       paused
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]       press;
  run_state_e       state;
  run_state_e       state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             tick_nxt;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_key (
      .clk  (CLK),
      .rst  (RST),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end

  assign clr_pulse = press[0];
  assign running   = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    if (press[1]) begin
      unique case (state)
        ST_RUN:    state_nxt = ST_PAUSED;
        ST_PAUSED: state_nxt = ST_RUN;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  // Clear wins over the terminal count, so a tick coinciding
  // with a clear is dropped and the count restarts from 0.
  always_comb begin
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    if (press[0]) begin
      cnt_nxt = '0;
    end else if (state == ST_RUN) begin
      if (cnt == DIV_LAST) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_RUN;
      paused <= 1'b0;
      cnt    <= '0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nxt;
      paused <= (state_nxt == ST_PAUSED);
      cnt    <= cnt_nxt;
      tick   <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_timebase_ctrl.sv
// Testbench for timebase_ctrl with DIV=5, DB_CYCLES=4: directed scenarios
// plus randomized key activity against a cycle-level reference model.
module tb_timebase_ctrl;

  localparam int DIV = 5;
  localparam int DB  = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] key_n;
  logic       tick;
  logic       clr_pulse;
  logic       running;
  logic       paused;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_p1[2];
  int m_p2[2];
  int m_level[2];
  int m_age[2];
  bit m_press[2];
  bit m_run;
  bit m_tick;
  int m_phase;

  always #5 CLK = ~CLK;

  timebase_ctrl #(
    .DIV      (DIV),
    .DIV_W    (3),
    .DB_CYCLES(DB),
    .DB_W     (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .key_n    (key_n),
    .tick     (tick),
    .clr_pulse(clr_pulse),
    .running  (running),
    .paused   (paused)
  );

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p1[k] = 1; m_p2[k] = 1; m_level[k] = 1;
      m_age[k] = 0; m_press[k] = 0;
    end
    m_run = 1; m_tick = 0; m_phase = 0;
  endfunction

  // One clock edge: presses visible before the edge act on the
  // prescaler and state; each key is judged on its value 2 edges ago.
  function automatic void model_step(logic [1:0] kn);
    bit clr;
    bit tog;
    int seen;
    clr = m_press[0];
    tog = m_press[1];
    m_tick = 0;
    if (clr) m_phase = 0;
    else if (m_run) begin
      m_phase = m_phase + 1;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_tick = 1;
      end
    end
    if (tog) m_run = !m_run;
    for (int k = 0; k < 2; k++) begin
      seen = m_p2[k];
      m_p2[k] = m_p1[k];
      m_p1[k] = int'(kn[k]);
      m_press[k] = 0;
      if (seen != m_level[k]) begin
        m_age[k] = m_age[k] + 1;
        if (m_age[k] == DB) begin
          m_level[k] = seen;
          m_age[k] = 0;
          m_press[k] = (seen == 0);
        end
      end else m_age[k] = 0;
    end
  endfunction

  task automatic cyc();
    @(posedge CLK);
    if (RST) model_reset();
    else model_step(key_n);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    key_n = 2'b11;
    model_reset();
    cyc();
    cyc();
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got %b want 0", tick);
    end
    checks++;
    if (clr_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_clr got %b want 0", clr_pulse);
    end
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL reset_running got %b want 1", running);
    end
    checks++;
    if (paused !== 1'b0) begin
      errors++; $display("FAIL reset_paused got %b want 0", paused);
    end
    RST = 1'b0;
  endtask

  task automatic test_idle();
    for (int n = 1; n <= 16; n++) begin
      cyc();
      checks++;
      if (tick !== (n % DIV == 0)) begin
        errors++; $display("FAIL idle_tick c%0d got %b want %b", n, tick, n % DIV == 0);
      end
      checks++;
      if (clr_pulse !== 1'b0 || running !== 1'b1) begin
        errors++; $display("FAIL idle_state c%0d got clr=%b run=%b want 0 1", n, clr_pulse, running);
      end
    end
  endtask

  task automatic test_pause_resume();
    int held;
    key_n[1] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      checks++;
      if (running !== (n < 7) || paused !== (n >= 7)) begin
        errors++; $display("FAIL pause c%0d got run=%b pau=%b want %b", n, running, paused, n < 7);
      end
    end
    key_n[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      checks++;
      if (tick !== 1'b0 || running !== 1'b0) begin
        errors++; $display("FAIL paused_hold c%0d got tick=%b run=%b want 0 0", n, tick, running);
      end
    end
    held = m_phase;
    key_n[1] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 10) key_n[1] = 1'b1;
      checks++;
      if (running !== (n >= 7)) begin
        errors++; $display("FAIL resume_run c%0d got %b want %b", n, running, n >= 7);
      end
      if (n <= 7 + DIV - held) begin
        checks++;
        if (tick !== (n == 7 + DIV - held)) begin
          errors++; $display("FAIL resume_tick c%0d held=%0d got %b want %b", n, held, tick, n == 7 + DIV - held);
        end
      end
    end
  endtask

  task automatic test_clear();
    key_n[0] = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      cyc();
      if (n == 3) key_n[0] = 1'b1;
      checks++;
      if (clr_pulse !== 1'b0) begin
        errors++; $display("FAIL glitch_clr c%0d got %b want 0", n, clr_pulse);
      end
    end
    key_n[0] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 8) key_n[0] = 1'b1;
      checks++;
      if (clr_pulse !== (n == 6)) begin
        errors++; $display("FAIL clear_pulse c%0d got %b want %b", n, clr_pulse, n == 6);
      end
      if (n >= 7 && n <= 12) begin
        checks++;
        if (tick !== (n == 12)) begin
          errors++; $display("FAIL clear_tick c%0d got %b want %b", n, tick, n == 12);
        end
      end
    end
  endtask

  task automatic test_clear_terminal();
    for (int w = 0; w < 10 && m_phase != 3; w++) cyc();
    checks++;
    if (m_phase != 3 || running !== 1'b1) begin
      errors++; $display("FAIL term_align got phase=%0d run=%b want 3 1", m_phase, running);
    end
    key_n[0] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 8) key_n[0] = 1'b1;
      checks++;
      if (clr_pulse !== (n == 6)) begin
        errors++; $display("FAIL term_clr c%0d got %b want %b", n, clr_pulse, n == 6);
      end
      if (n >= 7 && n <= 12) begin
        checks++;
        if (tick !== (n == 12)) begin
          errors++; $display("FAIL term_tick c%0d got %b want %b", n, tick, n == 12);
        end
      end
    end
  endtask

  task automatic test_clear_toggle();
    key_n = 2'b00;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 8) key_n = 2'b11;
      checks++;
      if (clr_pulse !== (n == 6) || running !== (n < 7)) begin
        errors++; $display("FAIL both c%0d got clr=%b run=%b want %b %b", n, clr_pulse, running, n == 6, n < 7);
      end
      if (n >= 7) begin
        checks++;
        if (tick !== 1'b0) begin
          errors++; $display("FAIL both_tick c%0d got %b want 0", n, tick);
        end
      end
    end
    // resume from a cleared count: first tick a full period later
    key_n[1] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 8) key_n[1] = 1'b1;
      checks++;
      if (running !== (n >= 7)) begin
        errors++; $display("FAIL both_resume c%0d got %b want %b", n, running, n >= 7);
      end
      if (n <= 12) begin
        checks++;
        if (tick !== (n == 12)) begin
          errors++; $display("FAIL both_resume_tick c%0d got %b want %b", n, tick, n == 12);
        end
      end
    end
    // pause, clear while paused, resume
    key_n[1] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 8) key_n[1] = 1'b1;
    end
    key_n[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 8) key_n[0] = 1'b1;
      checks++;
      if (running !== 1'b0 || clr_pulse !== (n == 6)) begin
        errors++; $display("FAIL pclr c%0d got run=%b clr=%b want 0 %b", n, running, clr_pulse, n == 6);
      end
    end
    key_n[1] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (n == 8) key_n[1] = 1'b1;
      checks++;
      if (tick !== (n == 12)) begin
        errors++; $display("FAIL pclr_tick c%0d got %b want %b", n, tick, n == 12);
      end
    end
  endtask

  task automatic test_reset_mid();
    key_n[1] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 8) key_n[1] = 1'b1;
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL mid_pre got run=%b want 0", running);
    end
    key_n[0] = 1'b0;
    for (int n = 1; n <= 4; n++) cyc();
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (tick !== 1'b0 || clr_pulse !== 1'b0 || running !== 1'b1 || paused !== 1'b0) begin
      errors++; $display("FAIL mid_async got t=%b c=%b r=%b p=%b want 0 0 1 0", tick, clr_pulse, running, paused);
    end
    key_n = 2'b11;
    cyc();
    RST = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      checks++;
      if (running !== 1'b1 || clr_pulse !== 1'b0 || tick !== (n % DIV == 0)) begin
        errors++; $display("FAIL mid_after c%0d got r=%b c=%b t=%b want 1 0 %b", n, running, clr_pulse, tick, n % DIV == 0);
      end
    end
  endtask

  task automatic test_random();
    int run_len[2];
    run_len[0] = 0;
    run_len[1] = 0;
    for (int n = 0; n < 1200; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (run_len[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          run_len[k] = $urandom_range(1, 9);
        end
        run_len[k]--;
      end
      cyc();
      checks++;
      if (tick !== m_tick || clr_pulse !== m_press[0] || running !== m_run || paused !== !m_run) begin
        errors++;
        $display("FAIL rand c%0d got t=%b c=%b r=%b p=%b want %b %b %b %b", n, tick, clr_pulse, running, paused, m_tick, m_press[0], m_run, !m_run);
      end
    end
    key_n = 2'b11;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pause_resume();
    test_clear();
    test_clear_terminal();
    test_clear_toggle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
